// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, syncs and
// frame/line strobes, all registered and aligned to the same x/y.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW           = 10;
    localparam int unsigned FW           = 8;
    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [FW-1:0] r_frame_count;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_display_on;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_frame_wrap;
    logic          w_hs_active;
    logic          w_vs_active;
    logic          w_display_on;
    logic          w_line_start;
    logic          w_frame_start;

    // Next raster position; qualifiers derive from it so they line up with x/y.
    // Comparisons use one extra bit so a sync end of 1024 stays representable.
    always_comb begin
        w_x_last      = (r_x == CW'(H_TOTAL - 1));
        w_y_last      = (r_y == CW'(V_TOTAL - 1));
        w_x_nxt       = r_x + CW'(1);
        w_y_nxt       = r_y;
        w_frame_wrap  = 1'b0;
        if (w_x_last) begin
            w_x_nxt = '0;
            if (w_y_last) begin
                w_y_nxt      = '0;
                w_frame_wrap = 1'b1;
            end else begin
                w_y_nxt = r_y + CW'(1);
            end
        end
        w_hs_active   = ({1'b0, w_x_nxt} >= (CW+1)'(H_SYNC_START)) &&
                        ({1'b0, w_x_nxt} <  (CW+1)'(H_SYNC_END));
        w_vs_active   = ({1'b0, w_y_nxt} >= (CW+1)'(V_SYNC_START)) &&
                        ({1'b0, w_y_nxt} <  (CW+1)'(V_SYNC_END));
        w_display_on  = ({1'b0, w_x_nxt} < (CW+1)'(H_DISPLAY)) &&
                        ({1'b0, w_y_nxt} < (CW+1)'(V_DISPLAY));
        w_line_start  = (w_x_nxt == '0);
        w_frame_start = (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    // Reset parks the raster on the last pixel of the last line so the first
    // enabled edge opens frame 1; a frozen raster never repeats its strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x           <= CW'(H_TOTAL - 1);
            r_y           <= CW'(V_TOTAL - 1);
            r_frame_count <= '0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ena) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_frame_count <= w_frame_wrap ? r_frame_count + FW'(1) : r_frame_count;
            r_hsync       <= w_hs_active ? H_SYNC_POL : ~H_SYNC_POL;
            r_vsync       <= w_vs_active ? V_SYNC_POL : ~V_SYNC_POL;
            r_display_on  <= w_display_on;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a per-cycle reference model feeding a scoreboard
// for a default-timing and a shrunken-timing instance, plus a vector table.
module tb_vga_timing_gen;

    typedef struct {
        int   x;
        int   y;
        int   fc;
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
    } obs_t;

    typedef struct {
        string name;
        logic  r;
        logic  e;
        int    n;
        obs_t  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;

    logic [9:0] d0_x, d0_y, d1_x, d1_y;
    logic [7:0] d0_fc, d1_fc;
    logic       d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
    logic       d1_hs, d1_vs, d1_de, d1_ls, d1_fs;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Timing of instance 0 (default) and instance 1 (small raster).
    int HD[2] = '{640, 8};
    int HF[2] = '{16, 1};
    int HS[2] = '{96, 2};
    int HB[2] = '{48, 1};
    int VD[2] = '{480, 4};
    int VF[2] = '{10, 1};
    int VS[2] = '{2, 2};
    int VB[2] = '{33, 1};

    int   mx[2];
    int   my[2];
    int   mfc[2];
    obs_t q0[$];
    obs_t q1[$];

    always #20 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .x(d0_x), .y(d0_y), .hsync(d0_hs), .vsync(d0_vs),
        .display_on(d0_de), .line_start(d0_ls), .frame_start(d0_fs),
        .frame_count(d0_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .x(d1_x), .y(d1_y), .hsync(d1_hs), .vsync(d1_vs),
        .display_on(d1_de), .line_start(d1_ls), .frame_start(d1_fs),
        .frame_count(d1_fc)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".x"},  a.x,  e.x);
        check({tag, ".y"},  a.y,  e.y);
        check({tag, ".fc"}, a.fc, e.fc);
        check({tag, ".hsync"}, int'(a.hs), int'(e.hs));
        check({tag, ".vsync"}, int'(a.vs), int'(e.vs));
        check({tag, ".display_on"}, int'(a.de), int'(e.de));
        check({tag, ".line_start"}, int'(a.ls), int'(e.ls));
        check({tag, ".frame_start"}, int'(a.fs), int'(e.fs));
    endtask

    function automatic obs_t get_obs(input int k);
        obs_t o;
        if (k == 0) begin
            o = '{int'(d0_x), int'(d0_y), int'(d0_fc), d0_hs, d0_vs, d0_de, d0_ls, d0_fs};
        end else begin
            o = '{int'(d1_x), int'(d1_y), int'(d1_fc), d1_hs, d1_vs, d1_de, d1_ls, d1_fs};
        end
        return o;
    endfunction

    // Outputs describing the model's current position (active-low syncs).
    function automatic obs_t predict(input int k, input bit strobes);
        obs_t o;
        int   hss = HD[k] + HF[k];
        int   vss = VD[k] + VF[k];
        o.x  = mx[k];
        o.y  = my[k];
        o.fc = mfc[k];
        o.hs = !(mx[k] >= hss && mx[k] < hss + HS[k]);
        o.vs = !(my[k] >= vss && my[k] < vss + VS[k]);
        o.de = (mx[k] < HD[k]) && (my[k] < VD[k]);
        o.ls = strobes && (mx[k] == 0);
        o.fs = strobes && (mx[k] == 0) && (my[k] == 0);
        return o;
    endfunction

    task automatic advance(input int k, input logic r, input logic e);
        int   ht = HD[k] + HF[k] + HS[k] + HB[k];
        int   vt = VD[k] + VF[k] + VS[k] + VB[k];
        obs_t o;
        if (!r) begin
            mx[k]  = ht - 1;
            my[k]  = vt - 1;
            mfc[k] = 0;
            o = predict(k, 1'b0);
        end else if (e) begin
            if (mx[k] == ht - 1) begin
                mx[k] = 0;
                if (my[k] == vt - 1) begin
                    my[k]  = 0;
                    mfc[k] = (mfc[k] + 1) % 256;
                end else begin
                    my[k] = my[k] + 1;
                end
            end else begin
                mx[k] = mx[k] + 1;
            end
            o = predict(k, 1'b1);
        end else begin
            o = predict(k, 1'b0);
        end
        if (k == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    task automatic step(input logic r, input logic e);
        obs_t exp;
        @(negedge clk);
        rst_n = r;
        ena   = e;
        advance(0, r, e);
        advance(1, r, e);
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (q0.size() == 0 || q1.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at cycle %0d: got size %0d/%0d, expected nonzero",
                     cyc, q0.size(), q1.size());
        end else begin
            exp = q0.pop_front();
            compare_obs("sb0", get_obs(0), exp);
            exp = q1.pop_front();
            compare_obs("sb1", get_obs(1), exp);
        end
    endtask

    initial begin
        vec_t vt[$];
        int   n_vs, n_de, n_fs, n_ls;
        obs_t o;

        //                name          r     e     n    x    y   fc  hs    vs    de    ls    fs
        vt.push_back('{"reset",       1'b0, 1'b1, 1,  '{799, 524, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"first_edge",  1'b1, 1'b1, 1,  '{0,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}});
        vt.push_back('{"hold",        1'b1, 1'b0, 10, '{0,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}});
        vt.push_back('{"resume",      1'b1, 1'b1, 1,  '{1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}});
        vt.push_back('{"last_vis",    1'b1, 1'b1, 638,'{639, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}});
        vt.push_back('{"de_fall",     1'b1, 1'b1, 1,  '{640, 0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"pre_hsync",   1'b1, 1'b1, 15, '{655, 0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"hsync_on",    1'b1, 1'b1, 1,  '{656, 0,   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"hsync_last",  1'b1, 1'b1, 95, '{751, 0,   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"hsync_off",   1'b1, 1'b1, 1,  '{752, 0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"line_end",    1'b1, 1'b1, 47, '{799, 0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"line1",       1'b1, 1'b1, 1,  '{0,   1,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}});
        vt.push_back('{"mid_line",    1'b1, 1'b1, 300,'{300, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}});
        vt.push_back('{"mid_reset",   1'b0, 1'b1, 1,  '{799, 524, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"rst_over_ena",1'b0, 1'b0, 2,  '{799, 524, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"idle_parked", 1'b1, 1'b0, 3,  '{799, 524, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{"restart",     1'b1, 1'b1, 1,  '{0,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}});

        for (int i = 0; i < vt.size(); i++) begin
            repeat (vt[i].n) step(vt[i].r, vt[i].e);
            compare_obs(vt[i].name, get_obs(0), vt[i].exp);
        end

        // One full small frame: vsync 2 lines x 12, display 8x4, one frame_start, 8 line_starts.
        n_vs = 0; n_de = 0; n_fs = 0; n_ls = 0;
        for (int i = 0; i < 96; i++) begin
            step(1'b1, 1'b1);
            o = get_obs(1);
            if (!o.vs) n_vs++;
            if (o.de)  n_de++;
            if (o.fs)  n_fs++;
            if (o.ls)  n_ls++;
        end
        check("small_vsync_cycles", n_vs, 24);
        check("small_display_cycles", n_de, 32);
        check("small_frame_starts", n_fs, 1);
        check("small_line_starts", n_ls, 8);
        check("small_fc_after_frame", int'(d1_fc), 2);

        // Walk the small raster to the frame-count wrap.
        repeat (254 * 96 - 1) step(1'b1, 1'b1);
        check("small_fc_pre_wrap", int'(d1_fc), 255);
        step(1'b1, 1'b1);
        check("small_fc_wrap", int'(d1_fc), 0);
        check("small_fs_at_wrap", int'(d1_fs), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator that produces the pixel coordinates and sync signals for the whole display pipeline. It sits directly upstream of the text/graphics overlay stages: its registered `x`/`y` feed the overlay lookups (which index by `x[9:3]`, `y[8:3]`), and its `display_on`/sync outputs go to the pixel output stage. Default timing is 640x480 @ 60 Hz with a 25.175 MHz pixel clock (25 MHz acceptable).

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `H_SYNC_POL`, 0, hsync active level (0 = active-low)
- `V_SYNC_POL`, 0, vsync active level (0 = active-low)
- `clk`  input  1  pixel clock; all state on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `ena`  input  1  count enable; low freezes the raster
- `x`  output  10  current horizontal position, 0..H_TOTAL-1
- `y`  output  10  current vertical position, 0..V_TOTAL-1
- `hsync`  output  1  horizontal sync, polarity per H_SYNC_POL
- `vsync`  output  1  vertical sync, polarity per V_SYNC_POL
- `display_on`  output  1  high when x < H_DISPLAY and y < V_DISPLAY
- `line_start`  output  1  one-cycle strobe, high when x == 0
- `frame_start`  output  1  one-cycle strobe, high when x == 0 and y == 0
- `frame_count`  output  8  frames started since reset, wraps 255 -> 0

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤ 1024; no elaboration-time fallback.
- Reset (rst_n low at a clock edge): x = H_TOTAL-1 (799), y = V_TOTAL-1 (524), hsync/vsync at inactive level (1 with defaults), display_on = 0, line_start = 0, frame_start = 0, frame_count = 0. Reset is a consistent "last pixel of last line" state.
- Each edge with rst_n high and ena high: x increments; at x == H_TOTAL-1, x wraps to 0 and y increments; at y == V_TOTAL-1 on that same edge, y wraps to 0 and frame_count increments (mod 256).
- The first enabled edge after reset therefore gives x=0, y=0, frame_start=1, line_start=1, frame_count=1.
- hsync active iff H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC (656..751). vsync active iff V_DISPLAY+V_FRONT ≤ y < V_DISPLAY+V_FRONT+V_SYNC (490..491). vsync transitions on the line boundary (with x == 0), not mid-line.
- ena low: x, y, frame_count, hsync, vsync, display_on hold; line_start and frame_start forced 0 (strobes never repeat for a held position). Reset overrides ena.
- Reset asserted mid-frame: next edge returns to reset state; no partial-frame count.

## Timing
- All outputs are registered; none combinational from inputs.
- hsync, vsync, display_on, line_start, frame_start are computed from the next-state counters, so they are valid in the same cycle as the x/y they describe (zero skew between coordinate and qualifiers).
- Downstream combinational overlay logic sees x/y one register stage old; the output stage is responsible for any further pixel alignment.
- Line period H_TOTAL cycles; frame period H_TOTAL*V_TOTAL = 420000 enabled cycles.

## Test plan
- Reset then 1 enabled edge -> x=0, y=0, line_start=1, frame_start=1, frame_count=1, display_on=1, hsync=1, vsync=1.
- Run one line -> display_on falls at x=640, hsync low for x=656..751 (96 cycles), line_start high only at x=0; y=1 at cycle 800.
- Run one full frame -> vsync low exactly for y=490..491 (1600 cycles), display_on=0 for all y ≥ 480, frame_start again after 420000 cycles with frame_count=2.
- Deassert ena for 10 cycles at x=0,y=0 -> x/y/frame_count frozen, frame_start/line_start 0 during hold; resumes at x=1.
- Assert rst_n low at x=300, y=200 -> next edge x=799, y=524, all strobes 0, frame_count=0.
- Run 256 frames (or force counters near wrap) -> frame_count wraps 255 -> 0 on the frame_start edge.
